// File: rtl/regfile_read_if.sv
// Operand-read stage bus: instruction input, writeback stream, and issued-operand output.
interface regfile_read_if #(parameter int XLEN = 32);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     IR_in;
    logic [31:0]     PC_in;
    logic            wb_valid;
    logic [4:0]      wb_address;
    logic [XLEN-1:0] wb_data;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     IR;
    logic [31:0]     PC;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;

    modport slave (
        input  in_valid, IR_in, PC_in, wb_valid, wb_address, wb_data, out_ready,
        output in_ready, out_valid, IR, PC, A, B
    );

    modport master (
        output in_valid, IR_in, PC_in, wb_valid, wb_address, wb_data, out_ready,
        input  in_ready, out_valid, IR, PC, A, B
    );
endinterface

// File: rtl/regfile_read.sv
// RV32I operand-read stage with integer register file and busy-bit scoreboard.
// Optional write-through bypass of same-cycle writeback enabled by REGREAD_BYPASS_EN.
module regfile_read #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input logic           clk,
    input logic           rst,
    regfile_read_if.slave bus
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [6:0]      opcode;
    logic [4:0]      rs1, rs2, rd;
    logic            uses_rs1, uses_rs2, writes_rd;
    logic            hazard, issue, wb_en;
    logic [NREG-1:0] busy, busy_chk, wb_mask, set_mask;
    logic [XLEN-1:0] regs [NREG];
    logic [XLEN-1:0] op_a, op_b;

    assign opcode = bus.IR_in[6:0];
    assign rs1    = bus.IR_in[19:15];
    assign rs2    = bus.IR_in[24:20];
    assign rd     = bus.IR_in[11:7];

    assign uses_rs1  = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
    assign uses_rs2  = (opcode == OP_RTYPE) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
    assign writes_rd = !(opcode == OP_STORE || opcode == OP_BRANCH) && (rd != 5'd0);

    assign wb_en = bus.wb_valid && (bus.wb_address != 5'd0);

    always_comb begin
        wb_mask = '0;
        if (wb_en) wb_mask[bus.wb_address] = 1'b1;
    end

`ifdef REGREAD_BYPASS_EN
    // A register being written back this cycle is already resolved.
    assign busy_chk = busy & ~wb_mask;
`else
    assign busy_chk = busy;
`endif

    assign hazard = (uses_rs1 && busy_chk[rs1]) ||
                    (uses_rs2 && busy_chk[rs2]) ||
                    (writes_rd && busy_chk[rd]);

    assign bus.in_ready = !rst && (!bus.out_valid || bus.out_ready) && !hazard;
    assign issue        = bus.in_valid && bus.in_ready;

    always_comb begin
        set_mask = '0;
        if (issue && writes_rd) set_mask[rd] = 1'b1;
    end

    always_comb begin
        op_a = (rs1 == 5'd0) ? '0 : regs[rs1];
        op_b = (rs2 == 5'd0) ? '0 : regs[rs2];
`ifdef REGREAD_BYPASS_EN
        if (wb_en && bus.wb_address == rs1) op_a = bus.wb_data;
        if (wb_en && bus.wb_address == rs2) op_b = bus.wb_data;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wb_en) begin
            regs[bus.wb_address] <= bus.wb_data;
        end
    end

    // Issue-side set is ORed after the writeback clear so it wins on collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy <= '0;
        else     busy <= (busy & ~wb_mask) | set_mask;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.IR        <= '0;
            bus.PC        <= '0;
            bus.A         <= '0;
            bus.B         <= '0;
        end else if (issue) begin
            bus.out_valid <= 1'b1;
            bus.IR        <= bus.IR_in;
            bus.PC        <= bus.PC_in;
            bus.A         <= op_a;
            bus.B         <= op_b;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_regfile_read.sv
// Directed bench for regfile_read: expected operands are modelled from a shadow register file.
module tb_regfile_read;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_read_if #(.XLEN(32)) bus ();

    regfile_read #(.XLEN(32), .NREG(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef REGREAD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [31:0] ir;
        logic [31:0] pc;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t        sb[$];
    exp_t        last;
    logic [31:0] mreg [32];
    int          vectors = 0;
    int          miscompares = 0;

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [4:0] lo);
        return {7'b0, rs2, rs1, 3'b010, lo, 7'b0100011};
    endfunction

    function automatic logic [31:0] beq(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] lo);
        return {7'b0, rs2, rs1, 3'b000, lo, 7'b1100011};
    endfunction

    function automatic logic [31:0] rd_model(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (BYP && bus.wb_valid && bus.wb_address == r) return bus.wb_data;
        return mreg[r];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] ir, input logic [31:0] pc,
                         input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                         input logic ordy);
        bus.in_valid   = iv;
        bus.IR_in      = ir;
        bus.PC_in      = pc;
        bus.wb_valid   = wv;
        bus.wb_address = wa;
        bus.wb_data    = wd;
        bus.out_ready  = ordy;
    endtask

    // One clock: check in_ready, predict issue, advance the shadow file, compare output.
    task automatic tick(input logic exp_rdy, input string tag);
        logic issued;
        exp_t e;
        #1;
        chk({tag, ".in_ready"}, {31'd0, bus.in_ready}, {31'd0, exp_rdy});
        issued = bus.in_valid && exp_rdy;
        if (issued) begin
            e.ir = bus.IR_in;
            e.pc = bus.PC_in;
            e.a  = rd_model(bus.IR_in[19:15]);
            e.b  = rd_model(bus.IR_in[24:20]);
            sb.push_back(e);
        end
        if (bus.wb_valid && bus.wb_address != 5'd0) mreg[bus.wb_address] = bus.wb_data;
        @(posedge clk);
        #1;
        if (issued) begin
            e    = sb.pop_front();
            last = e;
            chk({tag, ".out_valid"}, {31'd0, bus.out_valid}, 32'd1);
            chk({tag, ".IR"}, bus.IR, e.ir);
            chk({tag, ".PC"}, bus.PC, e.pc);
            chk({tag, ".A"},  bus.A,  e.a);
            chk({tag, ".B"},  bus.B,  e.b);
        end
    endtask

    task automatic check_held(input string tag);
        chk({tag, ".out_valid"}, {31'd0, bus.out_valid}, 32'd1);
        chk({tag, ".IR"}, bus.IR, last.ir);
        chk({tag, ".A"},  bus.A,  last.a);
        chk({tag, ".B"},  bus.B,  last.b);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, ".in_ready"},  {31'd0, bus.in_ready},  32'd0);
        chk({tag, ".out_valid"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, ".IR"}, bus.IR, 32'd0);
        chk({tag, ".PC"}, bus.PC, 32'd0);
        chk({tag, ".A"},  bus.A,  32'd0);
        chk({tag, ".B"},  bus.B,  32'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
        drive(1'b1, addi(5'd5, 5'd0, 12'd3), 32'h100, 1'b0, 5'd0, 32'd0, 1'b1);
        #3;
        check_reset_state("reset");
        drive(1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of operation clears busy and the register file.
        drive(1'b1, addi(5'd5, 5'd0, 12'd3), 32'h100, 1'b1, 5'd5, 32'hDEAD, 1'b1);
        tick(1'b1, "midrst_issue");
        drive(1'b1, add(5'd8, 5'd5, 5'd0), 32'h104, 1'b0, 5'd0, 32'd0, 1'b1);
        tick(1'b0, "midrst_stall");
        rst = 1'b1;
        #1;
        check_reset_state("midrst");
        for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
        drive(1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        drive(1'b1, addi(5'd6, 5'd5, 12'd0), 32'h108, 1'b0, 5'd0, 32'd0, 1'b1);
        tick(1'b1, "postrst_x5");
        chk("postrst_x5_zero", bus.A, 32'd0);

        // Independent issue.
        drive(1'b0, 32'd0, 32'd0, 1'b1, 5'd1, 32'h11, 1'b1);
        tick(1'b1, "wb_x1");
        chk("drain.out_valid", {31'd0, bus.out_valid}, 32'd0);
        drive(1'b0, 32'd0, 32'd0, 1'b1, 5'd2, 32'h22, 1'b1);
        tick(1'b1, "wb_x2");
        drive(1'b1, add(5'd3, 5'd1, 5'd2), 32'h200, 1'b1, 5'd6, 32'h0, 1'b1);
        tick(1'b1, "add_x3");
        drive(1'b1, addi(5'd9, 5'd3, 12'd0), 32'h204, 1'b0, 5'd0, 32'd0, 1'b1);
        tick(1'b0, "x3_busy");

        // RAW stall, resolved by writeback.
        drive(1'b1, addi(5'd4, 5'd0, 12'd7), 32'h300, 1'b1, 5'd3, 32'h33, 1'b1);
        tick(1'b1, "addi_x4");
        drive(1'b1, add(5'd6, 5'd4, 5'd4), 32'h304, 1'b0, 5'd0, 32'd0, 1'b1);
        tick(1'b0, "raw_stall");
        drive(1'b1, add(5'd6, 5'd4, 5'd4), 32'h304, 1'b1, 5'd4, 32'd7, 1'b1);
        tick(BYP, "raw_wb");
        if (!BYP) begin
            drive(1'b1, add(5'd6, 5'd4, 5'd4), 32'h304, 1'b0, 5'd0, 32'd0, 1'b1);
            tick(1'b1, "raw_late");
        end
        chk("raw.A", bus.A, 32'd7);
        chk("raw.B", bus.B, 32'd7);
        drive(1'b0, 32'd0, 32'd0, 1'b1, 5'd6, 32'hE, 1'b1);
        tick(1'b1, "wb_x6");

        // Back-pressure holds the output and blocks issue.
        drive(1'b1, addi(5'd10, 5'd1, 12'd1), 32'h400, 1'b0, 5'd0, 32'd0, 1'b0);
        tick(1'b1, "bp_issue");
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, add(5'd11, 5'd1, 5'd2), 32'h404, 1'b0, 5'd0, 32'd0, 1'b0);
            tick(1'b0, "bp_stall");
            check_held("bp_hold");
        end
        drive(1'b1, add(5'd11, 5'd1, 5'd2), 32'h404, 1'b0, 5'd0, 32'd0, 1'b1);
        tick(1'b1, "bp_release");
        drive(1'b0, 32'd0, 32'd0, 1'b1, 5'd10, 32'h12, 1'b1);
        tick(1'b1, "wb_x10");
        drive(1'b0, 32'd0, 32'd0, 1'b1, 5'd11, 32'h33, 1'b1);
        tick(1'b1, "wb_x11");

        // x0 is hardwired; stores and branches never claim their rd field.
        drive(1'b0, 32'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF, 1'b1);
        tick(1'b1, "wb_x0");
        drive(1'b1, add(5'd12, 5'd0, 5'd0), 32'h500, 1'b0, 5'd0, 32'd0, 1'b1);
        tick(1'b1, "read_x0");
        drive(1'b1, sw(5'd1, 5'd2, 5'd13), 32'h504, 1'b0, 5'd0, 32'd0, 1'b1);
        tick(1'b1, "sw");
        drive(1'b1, addi(5'd13, 5'd0, 12'd1), 32'h508, 1'b0, 5'd0, 32'd0, 1'b1);
        tick(1'b1, "sw_no_busy");
        drive(1'b1, beq(5'd1, 5'd2, 5'd13), 32'h50C, 1'b0, 5'd0, 32'd0, 1'b1);
        tick(1'b1, "beq_rd_ignored");
        drive(1'b1, beq(5'd13, 5'd1, 5'd0), 32'h510, 1'b0, 5'd0, 32'd0, 1'b1);
        tick(1'b0, "beq_rs1_busy");
        drive(1'b0, 32'd0, 32'd0, 1'b1, 5'd13, 32'h1, 1'b1);
        tick(1'b1, "wb_x13");
        drive(1'b1, beq(5'd13, 5'd12, 5'd0), 32'h514, 1'b1, 5'd12, 32'h0, 1'b1);
        tick(BYP, "beq_rs2_wb");

        // Issue set and writeback clear of the same register: set wins.
        drive(1'b1, addi(5'd15, 5'd0, 12'd2), 32'h600, 1'b1, 5'd15, 32'h55, 1'b1);
        tick(1'b1, "setclr_nonbusy");
        drive(1'b1, addi(5'd16, 5'd15, 12'd0), 32'h604, 1'b0, 5'd0, 32'd0, 1'b1);
        tick(1'b0, "setclr_x15_busy");
        drive(1'b1, addi(5'd16, 5'd15, 12'd0), 32'h604, 1'b1, 5'd15, 32'h66, 1'b1);
        tick(BYP, "x15_wb");
        if (!BYP) begin
            drive(1'b1, addi(5'd16, 5'd15, 12'd0), 32'h604, 1'b0, 5'd0, 32'd0, 1'b1);
            tick(1'b1, "x15_late");
        end
        chk("x15.A", bus.A, 32'h66);

        drive(1'b1, addi(5'd7, 5'd0, 12'd0), 32'h700, 1'b0, 5'd0, 32'd0, 1'b1);
        tick(1'b1, "addi_x7");
        drive(1'b1, addi(5'd7, 5'd7, 12'd1), 32'h704, 1'b1, 5'd7, 32'd5, 1'b1);
        tick(BYP, "x7_setclr");
        if (!BYP) begin
            drive(1'b1, addi(5'd7, 5'd7, 12'd1), 32'h704, 1'b0, 5'd0, 32'd0, 1'b1);
            tick(1'b1, "x7_late");
        end
        chk("x7.A", bus.A, 32'd5);
        drive(1'b1, addi(5'd14, 5'd7, 12'd0), 32'h708, 1'b0, 5'd0, 32'd0, 1'b1);
        tick(1'b0, "x7_still_busy");
        drive(1'b1, addi(5'd14, 5'd7, 12'd0), 32'h708, 1'b1, 5'd7, 32'd9, 1'b1);
        tick(BYP, "x7_wb2");
        if (!BYP) begin
            drive(1'b1, addi(5'd14, 5'd7, 12'd0), 32'h708, 1'b0, 5'd0, 32'd0, 1'b1);
            tick(1'b1, "x7_late2");
        end
        chk("x7.A2", bus.A, 32'd9);

        drive(1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
        tick(1'b1, "idle");
        chk("final.out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
